// File: rtl/dcache_axi_bridge_if.sv
// Signal bundle between the D-cache request port, the bridge, and the AXI4 interconnect.
// The master modport is the bridge's view; the slave modport is the cache/interconnect view.
interface dcache_axi_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic                  req_ena;
  logic                  req_we;
  logic [63:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_data;
  logic                  resp_err;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_W-1:0]     ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_W-1:0]     r_data;
  logic [1:0]            r_resp;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_W-1:0]     aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_W-1:0]     w_data;
  logic [DATA_W/8-1:0]   w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  modport master (
    input  req_ena, req_we, req_addr, req_wdata, req_wmask,
    output resp_valid, resp_data, resp_err,
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    output req_ena, req_we, req_addr, req_wdata, req_wmask,
    input  resp_valid, resp_data, resp_err,
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// D-cache miss/writeback responder: one request at a time, issued as a single-beat 64-bit
// AXI4 read or write, answered with a one-cycle completion pulse. All outputs are registered.
module dcache_axi_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input logic                 clk,
  input logic                 rst,
  dcache_axi_bridge_if.master bus
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAww, StB, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  b_ready_q, b_ready_d;
  logic                  resp_valid_q, resp_valid_d;

  // Offset bits and address bits above ADDR_W are intentionally dropped.
  logic unused_addr_bits;
  if (ADDR_W < 64) begin : g_addr_hi
    assign unused_addr_bits = ^{bus.req_addr[63:ADDR_W], bus.req_addr[2:0]};
  end else begin : g_addr_full
    assign unused_addr_bits = ^bus.req_addr[2:0];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_ena) begin
          addr_d    = {bus.req_addr[ADDR_W-1:3], 3'b000};
          wdata_d   = bus.req_wdata;
          wmask_d   = bus.req_wmask;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.req_we ? StAww : StAr;
        end
      end
      StAr: begin
        if (ar_valid_q && bus.ar_ready) state_d = StR;
      end
      StR: begin
        if (r_ready_q && bus.r_valid) begin
          resp_data_d = bus.r_data;
          resp_err_d  = (bus.r_resp != 2'b00);
          state_d     = StResp;
        end
      end
      StAww: begin
        // Address and data channels complete independently, possibly in the same cycle.
        aw_done_d = aw_done_q | (aw_valid_q & bus.aw_ready);
        w_done_d  = w_done_q | (w_valid_q & bus.w_ready);
        if (aw_done_d && w_done_d) state_d = StB;
      end
      StB: begin
        if (b_ready_q && bus.b_valid) begin
          resp_data_d = '0;
          resp_err_d  = (bus.b_resp != 2'b00);
          state_d     = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered copies of what the next state asserts.
    ar_valid_d   = (state_d == StAr);
    r_ready_d    = (state_d == StR);
    aw_valid_d   = (state_d == StAww) && !aw_done_d;
    w_valid_d    = (state_d == StAww) && !w_done_d;
    b_ready_d    = (state_d == StB);
    resp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      b_ready_q    <= b_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.ar_valid   = ar_valid_q;
  assign bus.ar_addr    = addr_q;
  assign bus.r_ready    = r_ready_q;
  assign bus.aw_valid   = aw_valid_q;
  assign bus.aw_addr    = addr_q;
  assign bus.w_valid    = w_valid_q;
  assign bus.w_data     = wdata_q;
  assign bus.w_strb     = wmask_q;
  assign bus.b_ready    = b_ready_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: a cycle-stepped AXI slave with per-channel delays
// and hand-computed expectations for latency, data, strobes and error flags.
module tb_dcache_axi_bridge;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dcache_axi_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observations from the last run_txn call.
  int                res_cycle, n_resp, n_ar, n_aw, n_w, ar_cyc, aw_cyc, w_cyc, addr_chg;
  logic [63:0]       res_data;
  logic              res_err;
  logic [ADDR_W-1:0] ar_seen, aw_seen;
  logic [63:0]       wd_seen;
  logic [7:0]        strb_seen;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic outs_any();
    return |{bus.resp_valid, bus.resp_data, bus.resp_err, bus.ar_valid, bus.ar_addr,
             bus.r_ready, bus.aw_valid, bus.aw_addr, bus.w_valid, bus.w_data, bus.w_strb,
             bus.b_ready};
  endfunction

  task automatic slave_idle();
    bus.ar_ready = 1'b0;
    bus.r_valid  = 1'b0;
    bus.r_data   = '0;
    bus.r_resp   = 2'b00;
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.b_resp   = 2'b00;
  endtask

  // Cycle c=1 is the first cycle after the accept edge; each ready/valid goes high at its delay.
  task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input int ar_dly, input int r_dly,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input logic [63:0] rdata, input logic [1:0] rsp,
                         input logic chain, input logic [63:0] next_addr);
    bus.req_ena   = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    tick();
    res_cycle = 0; n_resp = 0; n_ar = 0; n_aw = 0; n_w = 0;
    ar_cyc = 0; aw_cyc = 0; w_cyc = 0; addr_chg = 0;
    res_data = '0; res_err = 1'b0; ar_seen = '0; aw_seen = '0; wd_seen = '0; strb_seen = '0;
    for (int c = 1; c <= 60; c++) begin
      if (res_cycle != 0 && c > res_cycle) begin
        if (bus.resp_valid) n_resp++;
        break;
      end
      if (bus.resp_valid) begin
        n_resp++;
        res_cycle = c;
        res_data  = bus.resp_data;
        res_err   = bus.resp_err;
        if (chain) bus.req_addr = next_addr;
        else       bus.req_ena  = 1'b0;
      end
      if (bus.ar_valid) begin
        if (ar_cyc == 0) ar_seen = bus.ar_addr;
        else if (bus.ar_addr != ar_seen) addr_chg++;
        ar_cyc++;
      end
      if (bus.aw_valid) begin
        if (aw_cyc == 0) aw_seen = bus.aw_addr;
        else if (bus.aw_addr != aw_seen) addr_chg++;
        aw_cyc++;
      end
      if (bus.w_valid) begin
        if (w_cyc == 0) begin
          wd_seen   = bus.w_data;
          strb_seen = bus.w_strb;
        end else if ({bus.w_data, bus.w_strb} != {wd_seen, strb_seen}) addr_chg++;
        w_cyc++;
      end
      // Request inputs wiggle mid-transaction; the bridge must ignore them.
      if (c == 2) begin
        bus.req_addr  = bus.req_addr ^ 64'h0000_0000_0000_0FF8;
        bus.req_wdata = ~bus.req_wdata;
        bus.req_wmask = ~bus.req_wmask;
      end
      bus.ar_ready = (c >= ar_dly);
      bus.r_valid  = (c >= r_dly);
      bus.r_data   = rdata;
      bus.r_resp   = rsp;
      bus.aw_ready = (c >= aw_dly);
      bus.w_ready  = (c >= w_dly);
      bus.b_valid  = (c >= b_dly);
      bus.b_resp   = rsp;
      if (bus.ar_valid && bus.ar_ready) n_ar++;
      if (bus.aw_valid && bus.aw_ready) n_aw++;
      if (bus.w_valid && bus.w_ready)   n_w++;
      tick();
    end
    slave_idle();
  endtask

  initial begin
    int n;
    bus.req_ena   = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    slave_idle();

    rst = 1'b1;
    repeat (3) tick();
    check_eq("reset_outs_zero", 64'(outs_any()), 64'd0);
    rst = 1'b0;
    tick();

    // Minimum-latency read.
    run_txn(1'b0, 64'h8000_0013, 64'h0, 8'h0, 1, 1, 1, 1, 1, 64'h1122_3344_5566_7788, 2'b00,
            1'b0, 64'h0);
    check_eq("rd_ar_addr", 64'(ar_seen), 64'h8000_0010);
    check_eq("rd_latency", 64'(res_cycle), 64'd3);
    check_eq("rd_one_resp", 64'(n_resp), 64'd1);
    check_eq("rd_data", res_data, 64'h1122_3344_5566_7788);
    check_eq("rd_err", 64'(res_err), 64'd0);
    check_eq("rd_one_ar", 64'(n_ar), 64'd1);

    // Read with AR backpressure (ready at cycle 5) and R valid 5 cycles into R (cycle 11).
    run_txn(1'b0, 64'h8000_002C, 64'h0, 8'h0, 5, 11, 1, 1, 1, 64'hA5A5_0000_1234_5678, 2'b00,
            1'b0, 64'h0);
    check_eq("bp_ar_valid_cycles", 64'(ar_cyc), 64'd5);
    check_eq("bp_ar_stable", 64'(addr_chg), 64'd0);
    check_eq("bp_ar_addr", 64'(ar_seen), 64'h8000_0028);
    check_eq("bp_one_ar", 64'(n_ar), 64'd1);
    check_eq("bp_one_resp", 64'(n_resp), 64'd1);
    check_eq("bp_latency", 64'(res_cycle), 64'd12);
    check_eq("bp_data", res_data, 64'hA5A5_0000_1234_5678);

    // Write with split AW/W handshakes and delayed B.
    run_txn(1'b1, 64'h8000_0208, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1, 1, 1, 3, 5,
            64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'h0);
    check_eq("wr_aw_cycles", 64'(aw_cyc), 64'd1);
    check_eq("wr_w_cycles", 64'(w_cyc), 64'd3);
    check_eq("wr_aw_addr", 64'(aw_seen), 64'h8000_0208);
    check_eq("wr_w_data", wd_seen, 64'hDEAD_BEEF_0000_0000);
    check_eq("wr_w_strb", 64'(strb_seen), 64'hF0);
    check_eq("wr_stable", 64'(addr_chg), 64'd0);
    check_eq("wr_hs_count", 64'({n_aw[7:0], n_w[7:0], n_ar[7:0]}), 64'h01_01_00);
    check_eq("wr_latency", 64'(res_cycle), 64'd6);
    check_eq("wr_data_zero", res_data, 64'd0);
    check_eq("wr_err", 64'(res_err), 64'd0);

    // Error responses complete normally with resp_err set.
    run_txn(1'b0, 64'h8000_0400, 64'h0, 8'h0, 1, 1, 1, 1, 1, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10,
            1'b0, 64'h0);
    check_eq("rderr_err", 64'(res_err), 64'd1);
    check_eq("rderr_one_resp", 64'(n_resp), 64'd1);
    run_txn(1'b1, 64'h8000_0410, 64'h1234, 8'h0F, 1, 1, 1, 1, 1, 64'h0, 2'b11, 1'b0, 64'h0);
    check_eq("wrerr_err", 64'(res_err), 64'd1);
    check_eq("wrerr_latency", 64'(res_cycle), 64'd3);
    run_txn(1'b0, 64'h8000_0420, 64'h0, 8'h0, 1, 1, 1, 1, 1, 64'h0000_0000_CAFE_F00D, 2'b00,
            1'b0, 64'h0);
    check_eq("clean_err", 64'(res_err), 64'd0);
    check_eq("clean_data", res_data, 64'h0000_0000_CAFE_F00D);

    // Back-to-back: req_ena held through RESP, accepted in the next IDLE cycle.
    run_txn(1'b0, 64'h8000_0040, 64'h0, 8'h0, 1, 1, 1, 1, 1, 64'h1111_2222_3333_4444, 2'b00,
            1'b1, 64'h8000_0100);
    check_eq("b2b1_ar_addr", 64'(ar_seen), 64'h8000_0040);
    check_eq("b2b1_one_resp", 64'(n_resp), 64'd1);
    run_txn(1'b0, 64'h8000_0100, 64'h0, 8'h0, 1, 1, 1, 1, 1, 64'h5555_6666_7777_8888, 2'b00,
            1'b0, 64'h0);
    check_eq("b2b2_ar_addr", 64'(ar_seen), 64'h8000_0100);
    check_eq("b2b2_latency", 64'(res_cycle), 64'd3);
    check_eq("b2b2_data", res_data, 64'h5555_6666_7777_8888);

    // Reset while in R abandons the read silently.
    bus.req_ena  = 1'b1;
    bus.req_we   = 1'b0;
    bus.req_addr = 64'h8000_0300;
    tick();
    bus.ar_ready = 1'b1;
    tick();
    check_eq("rstmid_in_r", 64'(bus.r_ready), 64'd1);
    bus.ar_ready = 1'b0;
    bus.req_ena  = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("rstmid_outs_zero", 64'(outs_any()), 64'd0);
    rst = 1'b0;
    bus.r_valid = 1'b1;
    bus.r_data  = 64'hDEAD_DEAD_DEAD_DEAD;
    n = 0;
    repeat (4) begin
      if (bus.resp_valid) n++;
      tick();
    end
    check_eq("rstmid_no_resp", 64'(n), 64'd0);
    slave_idle();
    run_txn(1'b0, 64'h8000_0308, 64'h0, 8'h0, 1, 1, 1, 1, 1, 64'h0102_0304_0506_0708, 2'b00,
            1'b0, 64'h0);
    check_eq("post_rst_latency", 64'(res_cycle), 64'd3);
    check_eq("post_rst_data", res_data, 64'h0102_0304_0506_0708);
    check_eq("post_rst_ar_addr", 64'(ar_seen), 64'h8000_0308);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_axi_bridge.md
Name: dcache_axi_bridge

Overview:
Memory-side responder to the D-cache miss/writeback request port. It accepts one refill-read or dirty-writeback request at a time and performs it as a single-beat 64-bit AXI4 transaction. It returns a one-cycle completion pulse carrying the read data. It sits between the D-cache and the AXI interconnect.

Parameters:
ADDR_W, 32, AXI address width; req_addr[ADDR_W-1:0] is forwarded.
DATA_W, 64, data width; fixed at 64; strobe width is DATA_W/8.

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
req_ena  in  1  cache request; level, held by the cache until resp_valid
req_we  in  1  1 = writeback, 0 = refill read; sampled at accept
req_addr  in  64  request address; bits [2:0] ignored
req_wdata  in  64  writeback data; sampled at accept
req_wmask  in  8  writeback byte mask; sampled at accept
resp_valid  out  1  completion pulse, exactly 1 cycle
resp_data  out  64  read data; valid only with resp_valid; 0 for writes
resp_err  out  1  AXI error on this transaction; qualified by resp_valid
ar_valid  out  1  AXI read-address valid
ar_ready  in  1  AXI read-address ready
ar_addr  out  ADDR_W  read address, 8-byte aligned
r_valid  in  1  AXI read-data valid
r_ready  out  1  AXI read-data ready
r_data  in  64  AXI read data
r_resp  in  2  AXI read response
aw_valid  out  1  AXI write-address valid
aw_ready  in  1  AXI write-address ready
aw_addr  out  ADDR_W  write address, 8-byte aligned
w_valid  out  1  AXI write-data valid
w_ready  in  1  AXI write-data ready
w_data  out  64  write data
w_strb  out  8  write strobes = captured req_wmask
b_valid  in  1  AXI write-response valid
b_ready  out  1  AXI write-response ready
b_resp  in  2  AXI write response

Behaviour:
- Reset: state=IDLE. All outputs 0. Captured address, data and mask cleared. rst mid-transaction abandons the transaction with no resp_valid; the interconnect shares rst.
- All outputs are registered. The transaction is implicitly single-beat (LEN=0), SIZE=8 bytes, INCR.
- IDLE: when req_ena=1, capture {req_we, req_addr[ADDR_W-1:3],3'b000, req_wdata, req_wmask}. Go to AR if read, or AWW if write.
- AR: ar_valid=1 and ar_addr stay stable until ar_valid&ar_ready, then go to R. ar_valid deasserts the cycle after the handshake.
- R: r_ready=1. On r_valid, register resp_data=r_data and resp_err=(r_resp!=2'b00), then go to RESP. r_data arriving before the AR handshake completes is not possible; do not handle it.
- AWW: aw_valid and w_valid assert together. Each drops independently after its own handshake; track this with aw_done/w_done flags. The same-cycle double handshake is legal. When both are done, go to B.
- B: b_ready=1. On b_valid, resp_err=(b_resp!=2'b00), resp_data=0, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. The cache drops req_ena in the resp_valid cycle. req_ena high in the IDLE cycle after RESP is a new request.
- Only one outstanding request. While not IDLE, changes on the req_* inputs are ignored.
- Minimum read latency, with ready/valid all-1: accept at edge N, ar_valid in cycle N+1, R in N+2, resp_valid in N+3. Minimum write latency is the same, with AWW in place of AR and B in place of R.
- An error response does not retry or stall. It completes normally with resp_err=1.

Test Plan:
- Read, slave always ready: req_ena=1, req_we=0, req_addr=0x8000_0013, r_data=0x1122334455667788, r_resp=0 -> ar_addr=0x8000_0010. resp_valid one cycle, 3 cycles after accept, resp_data=0x1122334455667788, resp_err=0.
- Read with backpressure: ar_ready low 4 cycles, r_valid delayed 5 -> ar_valid and ar_addr stable throughout. Exactly one resp_valid. No second AR issued.
- Write, split handshakes: req_we=1, addr 0x8000_0208, wdata 0xDEADBEEF00000000, wmask 0xF0. aw_ready at cycle 1, w_ready at cycle 3, b_valid at cycle 5 -> aw_valid drops after cycle 1, w_valid after cycle 3, w_strb=0xF0. resp_valid after B, resp_data=0.
- Errors: r_resp=2'b10 on a read, then b_resp=2'b11 on a write -> each completes with resp_valid=1, resp_err=1. Next clean read has resp_err=0.
- Back-to-back: req_ena held high through RESP with the address changed to 0x8000_0100 -> second request accepted in the following IDLE cycle. Second ar_addr=0x8000_0100.
- Reset mid-op: assert rst for 1 cycle while in R -> next cycle all outputs 0, state IDLE, no resp_valid. A subsequent read completes normally.
